// File: rtl/puerta_pkg.sv
// Shared constants and encodings for the door motor driver.
// Command values match the door controller's 2-bit motor output.
package puerta_pkg;

    localparam logic [1:0] MOT_STOP  = 2'b00;
    localparam logic [1:0] MOT_OPEN  = 2'b01;
    localparam logic [1:0] MOT_CLOSE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } drv_state_e;

    typedef enum logic {
        DIR_OPEN  = 1'b0,
        DIR_CLOSE = 1'b1
    } dir_e;

    function automatic dir_e dir_flip(input dir_e d);
        return (d == DIR_OPEN) ? DIR_CLOSE : DIR_OPEN;
    endfunction

endpackage

// File: rtl/puerta_motor_driver_sync2.sv
// Two-flop synchronizer for one asynchronous level input; resets to 0.
// Output follows the input two clk edges later.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/puerta_motor_driver.sv
// H-bridge driver: dead time on every start/reversal, soft-start PWM ramp,
// limit-switch stop, travel timeout and implausible-limit fault latch.
module puerta_motor_driver
    import puerta_pkg::*;
#(
    parameter int PWM_BITS         = 8,
    parameter int RAMP_STEP_CYCLES = 50_000,
    parameter int DEAD_CYCLES      = 500_000,
    parameter int TIMEOUT_CYCLES   = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] motor,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       fault_clr,
    output logic       in_a,
    output logic       in_b,
    output logic       pwm,
    output logic       busy,
    output logic       fault
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int RW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0] motor_s;
    logic       lim_open_s, lim_closed_s;

    for (genvar i = 0; i < 2; i++) begin : g_motor_sync
        sync2 u_sync_motor (.clk(clk), .rst(rst), .d_i(motor[i]), .q_o(motor_s[i]));
    end
    sync2 u_sync_lo (.clk(clk), .rst(rst), .d_i(lim_open),   .q_o(lim_open_s));
    sync2 u_sync_lc (.clk(clk), .rst(rst), .d_i(lim_closed), .q_o(lim_closed_s));

    drv_state_e          state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [DW-1:0]       dead_cnt_q, dead_cnt_d;
    logic [RW-1:0]       ramp_cnt_q, ramp_cnt_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                in_a_q, in_b_q, pwm_q, busy_q, fault_q;

    logic [1:0] cmd;
    logic       both_lim, lim_ahead, cmd_opp;

    // 2'b11 is folded into stop so it can never select a direction.
    assign cmd       = (motor_s == MOT_OPEN || motor_s == MOT_CLOSE) ? motor_s : MOT_STOP;
    assign both_lim  = lim_open_s & lim_closed_s;
    assign lim_ahead = (dir_q == DIR_OPEN) ? lim_open_s : lim_closed_s;
    assign cmd_opp   = (dir_q == DIR_OPEN) ? (cmd == MOT_CLOSE) : (cmd == MOT_OPEN);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dead_cnt_d = '0;
        ramp_cnt_d = '0;
        tmo_cnt_d  = '0;
        duty_d     = '0;
        if (both_lim) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd == MOT_OPEN && !lim_open_s) begin
                        state_d = DEAD;
                        dir_d   = DIR_OPEN;
                    end else if (cmd == MOT_CLOSE && !lim_closed_s) begin
                        state_d = DEAD;
                        dir_d   = DIR_CLOSE;
                    end
                end
                DEAD: begin
                    if (cmd == MOT_STOP) begin
                        state_d = IDLE;
                    end else if (cmd_opp) begin
                        dir_d = dir_flip(dir_q);
                    end else if (dead_cnt_q == DEAD_LAST) begin
                        state_d = RUN;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (tmo_cnt_q == TMO_LAST) begin
                        state_d = FAULT;
                    end else if (lim_ahead || cmd == MOT_STOP) begin
                        state_d = IDLE;
                    end else if (cmd_opp) begin
                        state_d = DEAD;
                        dir_d   = dir_flip(dir_q);
                    end else begin
                        tmo_cnt_d  = tmo_cnt_q + 1'b1;
                        duty_d     = duty_q;
                        ramp_cnt_d = ramp_cnt_q + 1'b1;
                        if (ramp_cnt_q == RAMP_LAST) begin
                            ramp_cnt_d = '0;
                            if (duty_q != '1) duty_d = duty_q + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clr) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= DIR_OPEN;
            dead_cnt_q <= '0;
            ramp_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            duty_q     <= '0;
            pwm_cnt_q  <= '0;
            in_a_q     <= 1'b0;
            in_b_q     <= 1'b0;
            pwm_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            dead_cnt_q <= dead_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            in_a_q     <= (state_q == RUN) && (dir_q == DIR_OPEN);
            in_b_q     <= (state_q == RUN) && (dir_q == DIR_CLOSE);
            pwm_q      <= (state_q == RUN) && (pwm_cnt_q < duty_q);
            busy_q     <= (state_q == DEAD) || (state_q == RUN);
            fault_q    <= (state_q == FAULT);
        end
    end

    assign in_a  = in_a_q;
    assign in_b  = in_b_q;
    assign pwm   = pwm_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_puerta_motor_driver.sv
// Randomized bench for puerta_motor_driver with a scoreboard fed by a
// behavioural model; a separate monitor compares every registered output.
module tb_puerta_motor_driver;

    localparam int PWM_BITS = 4;
    localparam int RAMP     = 2;
    localparam int DEADC    = 4;
    localparam int TMO      = 100;
    localparam int PERIOD   = 1 << PWM_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] motor = 2'b00;
    logic       lim_open = 1'b0, lim_closed = 1'b0, fault_clr = 1'b0;
    logic       in_a, in_b, pwm, busy, fault;

    int checks = 0;
    int errors = 0;

    puerta_motor_driver #(
        .PWM_BITS(PWM_BITS), .RAMP_STEP_CYCLES(RAMP),
        .DEAD_CYCLES(DEADC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .motor(motor), .lim_open(lim_open),
        .lim_closed(lim_closed), .fault_clr(fault_clr),
        .in_a(in_a), .in_b(in_b), .pwm(pwm), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model: door mode, direction and elapsed time per phase.
    typedef enum int {M_IDLE, M_DEAD, M_RUN, M_FAULT} mode_e;
    mode_e    m_mode = M_IDLE;
    bit       m_open = 1'b1;
    int       dead_el = 0, run_el = 0, cyc = 0;
    bit [3:0] s1 = '0, s2 = '0;
    logic [4:0] exp_q[$];

    task automatic model_edge();
        logic [4:0] o;
        int  cmd, duty;
        bit  lo, lc, opp;
        if (rst) begin
            m_mode = M_IDLE; m_open = 1'b1; dead_el = 0; run_el = 0;
            cyc = 0; s1 = '0; s2 = '0; o = '0;
        end else begin
            duty = run_el / RAMP;
            if (duty > PERIOD - 1) duty = PERIOD - 1;
            o = {m_mode == M_RUN && m_open, m_mode == M_RUN && !m_open,
                 m_mode == M_RUN && (cyc % PERIOD) < duty,
                 m_mode == M_DEAD || m_mode == M_RUN, m_mode == M_FAULT};
            cmd = int'(s2[3:2]);
            if (cmd == 3) cmd = 0;
            lo  = s2[1];
            lc  = s2[0];
            opp = (cmd != 0) && ((cmd == 1) != m_open);
            if (lo && lc) m_mode = M_FAULT;
            else case (m_mode)
                M_IDLE: begin
                    if (cmd == 1 && !lo) begin m_mode = M_DEAD; m_open = 1'b1; dead_el = 0; end
                    else if (cmd == 2 && !lc) begin m_mode = M_DEAD; m_open = 1'b0; dead_el = 0; end
                end
                M_DEAD: begin
                    if (cmd == 0) m_mode = M_IDLE;
                    else if (opp) begin m_open = !m_open; dead_el = 0; end
                    else if (dead_el == DEADC - 1) begin m_mode = M_RUN; run_el = 0; end
                    else dead_el++;
                end
                M_RUN: begin
                    if (run_el == TMO - 1) m_mode = M_FAULT;
                    else if (m_open ? lo : lc) m_mode = M_IDLE;
                    else if (cmd == 0) m_mode = M_IDLE;
                    else if (opp) begin m_mode = M_DEAD; m_open = !m_open; dead_el = 0; end
                    else run_el++;
                end
                M_FAULT: if (fault_clr) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
            s2 = s1;
            s1 = {motor, lim_open, lim_closed};
            cyc++;
        end
        exp_q.push_back(o);
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] m, input logic lo, input logic lc,
                        input logic clr, input int n);
        rst = 1'b0; motor = m; lim_open = lo; lim_closed = lc; fault_clr = clr;
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: one scoreboard entry per clk edge, plus the bridge interlock.
    initial begin
        logic [4:0] o;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                o = exp_q.pop_front();
                checks++;
                if ({in_a, in_b, pwm, busy, fault} !== o) begin
                    errors++;
                    $display("FAIL outputs t=%0t {in_a,in_b,pwm,busy,fault} got %b expected %b",
                             $time, {in_a, in_b, pwm, busy, fault}, o);
                end
            end
            checks++;
            if (in_a && in_b) begin
                errors++;
                $display("FAIL interlock t=%0t in_a&in_b got 1 expected 0", $time);
            end
        end
    end

    initial begin
        #1;
        checks++;
        if ({in_a, in_b, pwm, busy, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got %b expected 00000", {in_a, in_b, pwm, busy, fault});
        end
        step();
        step();

        hold(2'b01, 0, 0, 0, 60);          // start, dead time, full ramp
        hold(2'b10, 0, 0, 0, 30);          // reversal
        hold(2'b10, 0, 1, 0, 12);          // limit stop, command still held
        hold(2'b00, 0, 0, 0, 5);
        hold(2'b01, 0, 0, 0, 120);         // travel timeout
        hold(2'b00, 0, 0, 0, 5);
        hold(2'b00, 0, 0, 1, 1);
        hold(2'b00, 0, 0, 0, 6);
        hold(2'b01, 0, 0, 0, 5);           // into DEAD
        hold(2'b01, 1, 1, 0, 6);           // implausible limits
        hold(2'b00, 1, 1, 1, 6);
        hold(2'b00, 0, 0, 1, 4);
        hold(2'b00, 0, 0, 0, 4);
        hold(2'b10, 0, 0, 0, 20);
        hold(2'b11, 0, 0, 0, 10);          // 11 behaves as stop

        hold(2'b01, 0, 0, 0, 20);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_a, in_b, pwm, busy, fault} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got %b expected 00000", {in_a, in_b, pwm, busy, fault});
        end
        step();
        step();

        for (int seg = 0; seg < 300; seg++) begin
            hold(2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, int'($urandom_range(1, 40)));
        end
        hold(2'b00, 0, 0, 1, 8);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puerta_motor_driver.md
# puerta_motor_driver

H-bridge driver stage placed directly downstream of the door controller FSM. It consumes the controller's 2-bit motor command (00 stop, 01 open, 10 close) and turns it into direction enables plus a soft-start PWM for the door motor. It enforces a dead time on every start and reversal, stops the motor at the end-of-travel limit switches, and latches a fault on travel timeout or an implausible limit-switch state.

## Interface

Parameters:
- `PWM_BITS`, default 8: PWM counter and duty width; PWM period is 2^PWM_BITS clk cycles.
- `RAMP_STEP_CYCLES`, default 50_000: clk cycles per +1 duty step during soft start.
- `DEAD_CYCLES`, default 500_000: bridge-off interval (10 ms at 50 MHz) before any drive.
- `TIMEOUT_CYCLES`, default 250_000_000: maximum RUN time (5 s) before a fault.

Ports:
- `clk`, input, 1 bit: 50 MHz system clock.
- `rst`, input, 1 bit: reset, asynchronous, active-high.
- `motor`, input, 2 bits: command from the door FSM. 00 stop, 01 open, 10 close, 11 treated as stop.
- `lim_open`, input, 1 bit: door fully open limit switch, active-high, asynchronous to clk.
- `lim_closed`, input, 1 bit: door fully closed limit switch, active-high, asynchronous to clk.
- `fault_clr`, input, 1 bit: clears a latched fault; level sampled.
- `in_a`, output, 1 bit: bridge leg A enable, set for the open direction.
- `in_b`, output, 1 bit: bridge leg B enable, set for the close direction.
- `pwm`, output, 1 bit: bridge PWM.
- `busy`, output, 1 bit: high in DEAD or RUN.
- `fault`, output, 1 bit: high in FAULT.

All outputs reset to 0. The FSM resets to IDLE, and the duty and all counters reset to 0.

## Operation

- `motor`, `lim_open` and `lim_closed` each pass through a 2-flop synchronizer. The FSM uses only the synchronized values.
- Direction register `dir`: open or close.

**States**
- **IDLE**: bridge off, duty = 0.
  - Command 01 with `!lim_open` → DEAD, dir = open.
  - Command 10 with `!lim_closed` → DEAD, dir = close.
  - A command toward an asserted limit is ignored; the FSM stays in IDLE.
- **DEAD**: bridge off; the dead counter counts up to `DEAD_CYCLES`-1.
  - Stop command → IDLE.
  - Opposite-direction command → update dir and restart the counter at 0.
  - Counter expiry → RUN, duty = 0, timeout counter = 0.
- **RUN**:
  - `in_a` = (dir == open), `in_b` = (dir == close).
  - `pwm` = (pwm_cnt < duty).
  - Duty increments every `RAMP_STEP_CYCLES` and saturates at 2^PWM_BITS-1.
  - Stop command → IDLE.
  - Opposite command → DEAD with the new dir.
  - Limit in the current direction asserted → IDLE.
  - Timeout counter reaching `TIMEOUT_CYCLES`-1 → FAULT.
- **FAULT**: bridge off, `fault` = 1.
  - `fault_clr` = 1 and both limits not simultaneously asserted → IDLE.
- Both synchronized limits high in any state → FAULT. This takes priority over every other transition.
- `in_a` and `in_b` are never both 1, and both are 0 outside RUN.
- `pwm_cnt` is free-running with a width of `PWM_BITS` and wraps from all-ones to 0. The maximum duty gives a high time of (2^PWM_BITS-1)/2^PWM_BITS.
- Simultaneous events on one edge, highest priority first: both-limits fault, timeout, limit stop, command change, ramp step.

## Timing

- All outputs are registered from the FSM state, dir, duty and pwm_cnt.
- Latency from an input change to an output change is 4 clk edges: 2 synchronizer edges, 1 state register, 1 output register.
- A start reaches first drive after 4 + `DEAD_CYCLES` edges. `pwm` stays 0 for the first `RAMP_STEP_CYCLES` of RUN, since duty is still 0.
- A reversal always passes through at least `DEAD_CYCLES` cycles with the bridge off. No path goes from RUN in one direction to RUN in the other without DEAD.
- Asserting `rst` mid-RUN forces the bridge off immediately (asynchronously) and lands in IDLE.
- The door FSM updates `motor` at about 1 Hz. This block treats the command as a level and runs only while it is held.

## Structure

- Shared package `puerta_pkg` holds:
  - Command constants MOT_STOP = 2'b00, MOT_OPEN = 2'b01, MOT_CLOSE = 2'b10.
  - Driver state encodings IDLE, DEAD, RUN, FAULT.
  - The dir encoding.
- Sub-module `sync2`: a 2-flop synchronizer with async active-high reset to 0. It is instantiated for each `motor` bit and for each limit switch.
- Everything else lives in `puerta_motor_driver`: FSM, dead counter, ramp counter, timeout counter and PWM counter.

## Test plan

All scenarios use PWM_BITS=4, RAMP_STEP_CYCLES=2, DEAD_CYCLES=4, TIMEOUT_CYCLES=100.

- **Reset then open**: reset, then hold `motor`=01 with limits low → `busy` rises 4 edges later; `in_a`=1 after a further 4 cycles; `pwm` duty ramps 0→15 over 30 cycles, then holds 15/16 high.
- **Reversal**: in RUN open, switch to `motor`=10 → `in_a` falls and `in_b` stays 0 for ≥4 cycles → then `in_b`=1 with duty restarting at 0; `in_a`&`in_b` never both 1.
- **Limit stop**: in RUN close, assert `lim_closed` → `in_b` and `pwm` are 0 within 4 edges; FSM in IDLE; holding `motor`=10 does not restart the motor.
- **Timeout**: RUN open with `lim_open` never asserting → `fault`=1 and bridge off at RUN cycle 100; pulse `fault_clr` → `fault`=0, IDLE.
- **Sensor fault**: assert `lim_open` and `lim_closed` together during DEAD → `fault`=1; `fault_clr` while both are still high keeps `fault`=1.
- **Stop and reset**: `motor`=11 during RUN → IDLE with all outputs 0; async `rst` mid-RUN → all outputs 0 before the next clk edge.
